ldst_unit: RTL and testbench
============================

# ldst_unit

Load/store sequencer between the decoder/register file and the 8-bit data memory. Accepts one load or store request per cycle and drives the memory's write-enable, address and write-data. Returns load results to the register file through a registered result port. Also supports 16-bit (wide) accesses, little-endian, split into two consecutive byte accesses, with a stall output during the second half.

## Interface

Parameters:
- W, 8, memory data width (bits per byte access)
- A, 8, memory address width; address space is 2**A bytes

Ports:
- Clk  input  1  single clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  1  request present this cycle (from decoder)
- ReqStore  input  1  1 = store, 0 = load; sampled when ReqValid
- ReqWide  input  1  1 = 2W-bit access at Addr, Addr+1; 0 = W-bit access
- Addr  input  A  byte address (register r1)
- WrData  input  2W  store data; only [W-1:0] is used when narrow
- Stall  output  1  high while a wide access occupies its second cycle; requests are ignored
- RdValid  output  1  one-cycle pulse: RdData holds a completed load result
- RdData  output  2W  load result; narrow loads are zero-extended
- MemWriteEn  output  1  to data memory WriteEn
- MemAddress  output  A  to data memory DataAddress
- MemDataIn  output  W  to data memory DataIn
- MemDataOut  input  W  from data memory DataOut (combinational read of MemAddress)

## Operation

- States: IDLE, SECOND. Registers: state, addr_q (A), hi_q (W, store high byte), lo_q (W, load low byte), op_store_q, RdValid, RdData.
- IDLE, ReqValid=0: MemWriteEn=0, MemAddress=Addr, MemDataIn=WrData[W-1:0]. Stay in IDLE.
- IDLE, narrow store: MemWriteEn=1, MemAddress=Addr, MemDataIn=WrData[W-1:0]. Stay in IDLE.
- IDLE, narrow load: MemAddress=Addr. At the posedge, RdData <= {W'0, MemDataOut} and RdValid <= 1.
- IDLE, wide store: writes the low byte as a narrow store. Latch addr_q <= Addr+1, hi_q <= WrData[2W-1:W] and op_store_q=1. Go to SECOND.
- IDLE, wide load: MemAddress=Addr. Latch lo_q <= MemDataOut, addr_q <= Addr+1 and op_store_q=0. Go to SECOND.
- SECOND: Stall=1. MemAddress=addr_q. All request inputs are ignored.
  - Store: MemWriteEn=1, MemDataIn=hi_q.
  - Load: MemWriteEn=0. At the posedge, RdData <= {MemDataOut, lo_q} and RdValid <= 1.
  - Always returns to IDLE.
- Address arithmetic: Addr+1 is modulo 2**A, so 2**A-1 wraps to 0.
- RdValid is cleared in any cycle that does not complete a load. RdData holds its last value until the next load completes.
- Reset=1, which overrides everything in the same cycle:
  - state <= IDLE; RdValid <= 0; RdData <= 0; addr_q, hi_q, lo_q <= 0.
  - MemWriteEn is forced to 0 combinationally.
  - A wide access in progress is abandoned: no second-byte write and no RdValid.

## Timing

- Narrow store: memory is written at the posedge ending the request cycle t. Stall stays 0.
- Narrow load: request in cycle t; RdValid=1 and RdData valid in cycle t+1.
- Wide store: low byte written at the end of t, high byte at the end of t+1. Stall=1 in t+1.
- Wide load: low byte read in t, high byte read in t+1. RdValid=1 in t+2. Stall=1 in t+1.
- Back-to-back narrow requests are accepted every cycle, so throughput is 1 per cycle.
- A wide request is followed by exactly one stall cycle. The next request is accepted in t+2.
- A load issued in t+1 immediately after a store to the same address in t returns the new data, because the write lands at the end of t.
- Stall is a Moore output (state==SECOND). Memory outputs are combinational from state and inputs.

## Test plan

- Reset: hold Reset for 2 cycles with ReqValid=1, ReqStore=1. Required: MemWriteEn=0 throughout. After release: RdValid=0, RdData=0, Stall=0.
- Narrow store then load: store 8'hA5 at 8'h10 in t, load 8'h10 in t+1. Required: RdValid=1 and RdData=16'h00A5 in t+2. Stall is never asserted.
- Wide round trip: wide store 16'hBEEF at 8'h20. Required: byte 8'h20=8'hEF and byte 8'h21=8'hBE, Stall=1 for one cycle. A following wide load of 8'h20 returns RdData=16'hBEEF two cycles after issue.
- Wrap-around: wide store 16'h1234 at 8'hFF. Required: byte 8'hFF=8'h34 and byte 8'h00=8'h12. A wide load at 8'hFF returns 16'h1234.
- Stall ignores input: during the SECOND cycle of a wide store at 8'h30, drive a narrow store of 8'h77 to 8'h40. Required: 8'h40 is unchanged; the second cycle writes only 8'h31.
- Reset mid-operation: wide store 16'hCAFE at 8'h50, then assert Reset in the SECOND cycle. Required: MemWriteEn=0 in that cycle, byte 8'h51 is not written with 8'hCA, and state is IDLE and Stall=0 after release.

Source files
------------

// File: rtl/ldst_unit.sv
// ldst_unit: load/store sequencer for a byte-wide data memory. Wide (2W) accesses
// are split little-endian into two byte cycles, with Stall high on the second.
module ldst_unit #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           ReqValid,
  input  logic           ReqStore,
  input  logic           ReqWide,
  input  logic [A-1:0]   Addr,
  input  logic [2*W-1:0] WrData,
  output logic           Stall,
  output logic           RdValid,
  output logic [2*W-1:0] RdData,
  output logic           MemWriteEn,
  output logic [A-1:0]   MemAddress,
  output logic [W-1:0]   MemDataIn,
  input  logic [W-1:0]   MemDataOut
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [A-1:0]     r_addr_q;
  logic [W-1:0]     r_hi_q;
  logic [W-1:0]     r_lo_q;
  logic             r_op_store_q;
  logic             r_rd_valid;
  logic [2*W-1:0]   r_rd_data;

  logic             w_write_req;
  logic [A-1:0]     w_mem_addr;
  logic [W-1:0]     w_mem_din;
  logic             w_load_done;
  logic [2*W-1:0]   w_load_data;
  logic             w_accept_wide;
  logic [A-1:0]     w_addr_inc;

  // Second-byte address wraps modulo 2**A by plain truncation.
  assign w_addr_inc    = Addr + {{(A-1){1'b0}}, 1'b1};
  assign w_accept_wide = (r_state == ST_IDLE) && ReqValid && ReqWide;

  // Next-state and memory-side controls; request inputs matter only in IDLE.
  always_comb begin
    w_next_state = ST_IDLE;
    w_write_req  = 1'b0;
    w_mem_addr   = Addr;
    w_mem_din    = WrData[W-1:0];
    w_load_done  = 1'b0;
    w_load_data  = {(2*W){1'b0}};
    case (r_state)
      ST_IDLE: begin
        w_load_data = {{W{1'b0}}, MemDataOut};
        if (ReqValid) begin
          w_write_req  = ReqStore;
          w_load_done  = !ReqStore && !ReqWide;
          w_next_state = ReqWide ? ST_SECOND : ST_IDLE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SECOND: begin
        w_mem_addr   = r_addr_q;
        w_mem_din    = r_hi_q;
        w_write_req  = r_op_store_q;
        w_load_done  = !r_op_store_q;
        w_load_data  = {MemDataOut, r_lo_q};
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Reset must block any write in its cycle, including an abandoned second byte.
  assign MemWriteEn = w_write_req && !Reset;
  assign MemAddress = w_mem_addr;
  assign MemDataIn  = w_mem_din;
  assign Stall      = (r_state == ST_SECOND);
  assign RdValid    = r_rd_valid;
  assign RdData     = r_rd_data;

  // State, wide-access latches and the registered load result port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_addr_q     <= {A{1'b0}};
      r_hi_q       <= {W{1'b0}};
      r_lo_q       <= {W{1'b0}};
      r_op_store_q <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= {(2*W){1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_rd_valid <= w_load_done;
      if (w_load_done) begin
        r_rd_data <= w_load_data;
      end
      if (w_accept_wide) begin
        r_addr_q     <= w_addr_inc;
        r_op_store_q <= ReqStore;
        if (ReqStore) begin
          r_hi_q <= WrData[2*W-1:W];
        end else begin
          r_lo_q <= MemDataOut;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldst_unit.sv
// Self-checking bench for ldst_unit: behavioural byte memory plus a queue of
// expected load results checked whenever RdValid pulses.
module tb_ldst_unit;

  localparam int W = 8;
  localparam int A = 8;

  logic           Clk;
  logic           Reset;
  logic           ReqValid;
  logic           ReqStore;
  logic           ReqWide;
  logic [A-1:0]   Addr;
  logic [2*W-1:0] WrData;
  logic           Stall;
  logic           RdValid;
  logic [2*W-1:0] RdData;
  logic           MemWriteEn;
  logic [A-1:0]   MemAddress;
  logic [W-1:0]   MemDataIn;
  logic [W-1:0]   MemDataOut;

  logic [W-1:0]   mem [0:255];
  logic [2*W-1:0] exp_q [$];
  logic [2*W-1:0] sb_exp;
  int             checks = 0;
  int             errors = 0;

  ldst_unit #(.W(W), .A(A)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqStore(ReqStore),
    .ReqWide(ReqWide), .Addr(Addr), .WrData(WrData), .Stall(Stall),
    .RdValid(RdValid), .RdData(RdData), .MemWriteEn(MemWriteEn),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (MemWriteEn === 1'b1) mem[MemAddress] <= MemDataIn;
  end
  assign MemDataOut = mem[MemAddress];

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i) ^ 8'h3C;
  endfunction

  // Scoreboard: every RdValid pulse must match the oldest expected load result.
  always @(negedge Clk) begin
    if (RdValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: RdValid with RdData=%h, expected no result", RdData);
      end else begin
        sb_exp = exp_q.pop_front();
        if (RdData !== sb_exp) begin
          errors++;
          $display("FAIL sb_rddata: got %h expected %h", RdData, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic w,
                       input logic [A-1:0] a, input logic [2*W-1:0] d);
    ReqValid = v; ReqStore = s; ReqWide = w; Addr = a; WrData = d;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h10, 16'h00FF);
    repeat (2) begin
      #1;
      checks++; if (MemWriteEn !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", MemWriteEn); end
      tick();
    end
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (RdValid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid: got %b expected 0", RdValid); end
    checks++; if (RdData !== 16'h0000) begin errors++; $display("FAIL reset_rddata: got %h expected 0000", RdData); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Stall); end
    checks++; if (mem[8'h10] !== init_byte(16'h10)) begin errors++; $display("FAIL reset_nowrite: got %h expected %h", mem[8'h10], init_byte(16'h10)); end
    tick();
  endtask

  task automatic test_narrow();
    drive(1'b1, 1'b1, 1'b0, 8'h10, 16'h00A5);
    #1;
    checks++; if (MemWriteEn !== 1'b1 || MemDataIn !== 8'hA5 || MemAddress !== 8'h10) begin errors++; $display("FAIL narrow_st_bus: got we=%b a=%h d=%h expected we=1 a=10 d=a5", MemWriteEn, MemAddress, MemDataIn); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL narrow_st_stall: got %b expected 0", Stall); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    exp_q.push_back(16'h00A5);
    #1;
    checks++; if (MemWriteEn !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL narrow_ld_ctl: got we=%b stall=%b expected 0 0", MemWriteEn, Stall); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (RdValid !== 1'b1 || RdData !== 16'h00A5) begin errors++; $display("FAIL narrow_ld_result: got v=%b d=%h expected v=1 d=00a5", RdValid, RdData); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL narrow_stall: got %b expected 0", Stall); end
    tick();
  endtask

  task automatic test_wide_round_trip();
    drive(1'b1, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    #1;
    checks++; if (MemWriteEn !== 1'b1 || MemAddress !== 8'h20 || MemDataIn !== 8'hEF) begin errors++; $display("FAIL wide_st_lo: got we=%b a=%h d=%h expected we=1 a=20 d=ef", MemWriteEn, MemAddress, MemDataIn); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL wide_st_stall: got %b expected 1", Stall); end
    checks++; if (MemWriteEn !== 1'b1 || MemAddress !== 8'h21 || MemDataIn !== 8'hBE) begin errors++; $display("FAIL wide_st_hi: got we=%b a=%h d=%h expected we=1 a=21 d=be", MemWriteEn, MemAddress, MemDataIn); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h20, 16'h0000);
    exp_q.push_back(16'hBEEF);
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL wide_st_unstall: got %b expected 0", Stall); end
    checks++; if (mem[8'h20] !== 8'hEF || mem[8'h21] !== 8'hBE) begin errors++; $display("FAIL wide_st_mem: got %h%h expected beef", mem[8'h21], mem[8'h20]); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (Stall !== 1'b1 || RdValid !== 1'b0) begin errors++; $display("FAIL wide_ld_t1: got stall=%b v=%b expected 1 0", Stall, RdValid); end
    tick();
    checks++; if (RdValid !== 1'b1 || RdData !== 16'hBEEF) begin errors++; $display("FAIL wide_ld_result: got v=%b d=%h expected v=1 d=beef", RdValid, RdData); end
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 16'h1234);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (MemAddress !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h expected 00", MemAddress); end
    tick();
    checks++; if (mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12) begin errors++; $display("FAIL wrap_mem: got ff=%h 00=%h expected ff=34 00=12", mem[8'hFF], mem[8'h00]); end
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 16'h0000);
    exp_q.push_back(16'h1234);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    checks++; if (RdData !== 16'h1234) begin errors++; $display("FAIL wrap_load: got %h expected 1234", RdData); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h60 + i), 16'(8'hC0 + i));
      #1;
      checks++; if (Stall !== 1'b0 || MemWriteEn !== 1'b1) begin errors++; $display("FAIL b2b_store%0d: got stall=%b we=%b expected 0 1", i, Stall, MemWriteEn); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 16'h0000);
      exp_q.push_back(16'(8'hC0 + i));
      #1;
      if (i > 0) begin
        checks++; if (RdValid !== 1'b1) begin errors++; $display("FAIL b2b_load%0d: got RdValid=%b expected 1", i, RdValid); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    tick();
  endtask

  task automatic test_stall_ignore();
    drive(1'b1, 1'b1, 1'b1, 8'h30, 16'h9988);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h40, 16'h0077);
    #1;
    checks++; if (MemAddress !== 8'h31 || MemDataIn !== 8'h99) begin errors++; $display("FAIL stall_bus: got a=%h d=%h expected a=31 d=99", MemAddress, MemDataIn); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (mem[8'h40] !== init_byte(16'h40)) begin errors++; $display("FAIL stall_ignored: got %h expected %h", mem[8'h40], init_byte(16'h40)); end
    checks++; if (mem[8'h30] !== 8'h88 || mem[8'h31] !== 8'h99) begin errors++; $display("FAIL stall_mem: got 30=%h 31=%h expected 88 99", mem[8'h30], mem[8'h31]); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL stall_end: got %b expected 0", Stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b1, 8'h50, 16'hCAFE);
    tick();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    checks++; if (MemWriteEn !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b expected 0", MemWriteEn); end
    tick();
    Reset = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", Stall); end
    checks++; if (mem[8'h50] !== 8'hFE || mem[8'h51] !== init_byte(16'h51)) begin errors++; $display("FAIL rstmid_mem: got 50=%h 51=%h expected fe %h", mem[8'h50], mem[8'h51], init_byte(16'h51)); end
    drive(1'b1, 1'b0, 1'b1, 8'h50, 16'h0000);
    tick();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    Reset = 1'b0;
    #1;
    checks++; if (RdValid !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL rstmid_ld_abandon: got v=%b stall=%b expected 0 0", RdValid, Stall); end
    drive(1'b1, 1'b0, 1'b0, 8'h51, 16'h0000);
    exp_q.push_back({8'h00, init_byte(16'h51)});
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
    test_reset();
    test_narrow();
    test_wide_round_trip();
    test_wrap();
    test_back_to_back();
    test_stall_ignore();
    test_reset_mid();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
